pmcc_sequencer: RTL

- Parametrised program-sequencing unit for the pixel-matrix coprocessor (PMCC).
- Generates the instruction-fetch address and tracks the executing-instruction address.
- Supports jump, call/return with a hardware return stack, nested hardware loops on a loop stack, and wait-on-trigger selectable from several trigger lines.
- Sits between the instruction memory (synchronous read, address = pc_if) and the PMCC instruction decoder, which supplies the decoded control inputs below.

---
 rtl/pmcc_seq_pkg.sv | 18 +
 rtl/pmcc_seq_stack.sv | 50 +++++
 rtl/pmcc_sequencer.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/pmcc_seq_pkg.sv
// Shared types for the PMCC program sequencer: error codes and the loop-stack entry layout.
package pmcc_seq_pkg;

  localparam int PMCC_PC_W  = 10;
  localparam int PMCC_CNT_W = 16;

  typedef enum logic [1:0] {
    PMCC_ERR_NONE = 2'd0,
    PMCC_ERR_LOOP = 2'd1,
    PMCC_ERR_CALL = 2'd2
  } pmcc_err_e;

  typedef struct packed {
    logic [PMCC_PC_W-1:0]  start;
    logic [PMCC_CNT_W-1:0] remaining;
  } pmcc_loop_entry_t;

endpackage

// File: rtl/pmcc_seq_stack.sv
// Generic synchronous LIFO with push, pop and in-place rewrite of the top entry.
module pmcc_seq_stack #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             wr_top_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic [WIDTH-1:0] top_data_i,
  output logic [WIDTH-1:0] top_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    top_cnt;
  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    wr_idx;

  assign top_cnt = cnt_q - CW'(1);
  assign top_idx = AW'(top_cnt);
  assign wr_idx  = AW'(cnt_q);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign top_o   = mem_q[top_idx];

  // Push wins over pop/rewrite; the caller never asks for more than one at a time.
  always_ff @(posedge clk) begin
    if (clr_i) begin
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_i && !full_o) begin
      mem_q[wr_idx] <= push_data_i;
      cnt_q         <= cnt_q + CW'(1);
    end else if (pop_i && !empty_o) begin
      cnt_q <= cnt_q - CW'(1);
    end else if (wr_top_i && !empty_o) begin
      mem_q[top_idx] <= top_data_i;
    end
  end

endmodule

// File: rtl/pmcc_sequencer.sv
// PMCC program sequencer: fetch-address generation with jump, call/return,
// nested hardware loops, trigger waits and sticky stack-fault halting.
module pmcc_sequencer
  import pmcc_seq_pkg::*;
#(
  parameter int PC_W       = 10,
  parameter int CNT_W      = 16,
  parameter int LOOP_DEPTH = 4,
  parameter int CALL_DEPTH = 4,
  parameter int TRIG_NUM   = 4,
  localparam int SEL_W     = $clog2(TRIG_NUM),
  localparam int LVL_W     = $clog2(LOOP_DEPTH + 1),
  localparam int CLV_W     = $clog2(CALL_DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                soft_rst,
  input  logic [TRIG_NUM-1:0] trigger,
  input  logic [1:0]          instr_size,
  input  logic                is_jump,
  input  logic                is_call,
  input  logic                is_ret,
  input  logic                is_loop,
  input  logic                is_endloop,
  input  logic                is_wait,
  input  logic [SEL_W-1:0]    wait_sel,
  input  logic [PC_W-1:0]     target,
  input  logic [CNT_W-1:0]    loop_cnt,
  output logic [PC_W-1:0]     pc_if,
  output logic [PC_W-1:0]     pc_id,
  output logic                waiting,
  output logic                halted,
  output logic [1:0]          err_code,
  output logic [LVL_W-1:0]    loop_level
);

  typedef struct packed {
    logic [PC_W-1:0]  start;
    logic [CNT_W-1:0] remaining;
  } loop_ent_t;

  logic             rst_any;
  logic [PC_W-1:0]  pc_id_q;
  logic             halted_q;
  pmcc_err_e        err_q;
  pmcc_err_e        err_d;
  logic [PC_W-1:0]  seq;
  logic [PC_W-1:0]  pc_d;
  logic             stall;
  logic             loop_err;
  logic             call_err;

  logic             call_push, call_pop;
  logic             call_full, call_empty;
  logic [PC_W-1:0]  call_top;
  logic [CLV_W-1:0] call_cnt;

  logic             loop_push, loop_pop, loop_wr;
  logic             loop_full, loop_empty;
  loop_ent_t        loop_top, loop_new, loop_upd;
  logic [LVL_W-1:0] loop_cnt_q;

  assign rst_any = rst | soft_rst;
  assign seq     = pc_id_q + PC_W'(instr_size) + PC_W'(1);

  always_comb begin
    pc_d      = seq;
    stall     = 1'b0;
    loop_err  = 1'b0;
    call_err  = 1'b0;
    call_push = 1'b0;
    call_pop  = 1'b0;
    loop_push = 1'b0;
    loop_pop  = 1'b0;
    loop_wr   = 1'b0;
    loop_new  = '{start: seq, remaining: (loop_cnt == '0) ? CNT_W'(1) : loop_cnt};
    loop_upd  = '{start: loop_top.start, remaining: loop_top.remaining - CNT_W'(1)};
    if (rst_any) begin
      pc_d = '0;
    end else if (halted_q) begin
      pc_d = pc_id_q;
    end else if (is_wait && !trigger[wait_sel]) begin
      pc_d  = pc_id_q;
      stall = 1'b1;
    end else if (is_jump) begin
      pc_d = target;
    end else if (is_call) begin
      if (call_full) call_err = 1'b1;
      else begin
        call_push = 1'b1;
        pc_d      = target;
      end
    end else if (is_ret) begin
      if (call_empty) call_err = 1'b1;
      else begin
        call_pop = 1'b1;
        pc_d     = call_top;
      end
    end else if (is_loop) begin
      if (loop_full) loop_err = 1'b1;
      else loop_push = 1'b1;
    end else if (is_endloop) begin
      if (loop_empty) loop_err = 1'b1;
      else if (loop_top.remaining > CNT_W'(1)) begin
        loop_wr = 1'b1;
        pc_d    = loop_top.start;
      end else begin
        loop_pop = 1'b1;
      end
    end
    // A faulting instruction holds the fetch address; stacks are already untouched.
    if (loop_err || call_err) pc_d = pc_id_q;
  end

  always_comb begin
    err_d = err_q;
    if (err_q == PMCC_ERR_NONE) begin
      if (loop_err)      err_d = PMCC_ERR_LOOP;
      else if (call_err) err_d = PMCC_ERR_CALL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_any) begin
      pc_id_q  <= '0;
      halted_q <= 1'b0;
      err_q    <= PMCC_ERR_NONE;
    end else begin
      pc_id_q  <= pc_d;
      halted_q <= halted_q | loop_err | call_err;
      err_q    <= err_d;
    end
  end

  pmcc_seq_stack #(.WIDTH(PC_W), .DEPTH(CALL_DEPTH)) u_call_stack (
    .clk         (clk),
    .clr_i       (rst_any),
    .push_i      (call_push),
    .pop_i       (call_pop),
    .wr_top_i    (1'b0),
    .push_data_i (seq),
    .top_data_i  ('0),
    .top_o       (call_top),
    .full_o      (call_full),
    .empty_o     (call_empty),
    .count_o     (call_cnt)
  );

  pmcc_seq_stack #(.WIDTH(PC_W + CNT_W), .DEPTH(LOOP_DEPTH)) u_loop_stack (
    .clk         (clk),
    .clr_i       (rst_any),
    .push_i      (loop_push),
    .pop_i       (loop_pop),
    .wr_top_i    (loop_wr),
    .push_data_i (loop_new),
    .top_data_i  (loop_upd),
    .top_o       (loop_top),
    .full_o      (loop_full),
    .empty_o     (loop_empty),
    .count_o     (loop_cnt_q)
  );

  assign pc_if      = pc_d;
  assign pc_id      = pc_id_q;
  assign waiting    = stall;
  assign halted     = halted_q;
  assign err_code   = err_d;
  assign loop_level = loop_cnt_q;

endmodule
